mult_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one iterative shift-add multiply engine between NREQ requesters.
- Each requester presents an operand pair and a request. The block grants one requester, latches its operands and sequences the add/shift iterations.
- Returns the product tagged with the requester index.
- Sits between requesting datapaths and the multiplier resource. Replaces per-client multipliers.

---
 rtl/mult_rr_scheduler.sv | 155 +++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// ============================================================================
// Module      : mult_rr_scheduler
// Description : Round-robin arbiter sharing one iterative shift-add multiplier
//               between NREQ requesters; product returned tagged with lane id.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_rr_scheduler #(
    parameter int W    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   mcand_in,
    input  logic [NREQ*W-1:0]   mplier_in,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic                done,
    output logic [IDW-1:0]      done_id,
    output logic [2*W-1:0]      prod
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [2*W-1:0]   prod_q, prod_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             any_req;
    logic [IDW-1:0]   sel;
    logic [2*W-1:0]   acc_sum;
    int               idx;

    // First requesting lane strictly after the last granted one, wrapping.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && (|(req & (NREQ'(1) << idx)))) begin
                any_req = 1'b1;
                sel     = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        id_d      = id_q;
        last_d    = last_q;
        done_id_d = done_id_q;
        prod_d    = prod_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        gnt       = '0;
        acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt      = NREQ'(1) << sel;
                    mcand_d  = {{W{1'b0}}, W'(mcand_in >> (int'(sel) * W))};
                    mplier_d = W'(mplier_in >> (int'(sel) * W));
                    acc_d    = '0;
                    count_d  = '0;
                    id_d     = sel;
                    last_d   = sel;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(W - 1)) begin
                    prod_d    = acc_sum;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            id_q      <= '0;
            last_q    <= IDW'(NREQ - 1);
            done_id_q <= '0;
            prod_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            id_q      <= id_d;
            last_q    <= last_d;
            done_id_q <= done_id_d;
            prod_q    <= prod_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign prod    = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_rr_scheduler.sv
// ============================================================================
// Module      : tb_mult_rr_scheduler
// Description : Self-checking bench: transaction-level model plus directed jobs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_rr_scheduler;

    localparam int W    = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   mcand_in;
    logic [NREQ*W-1:0]   mplier_in;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [2*W-1:0]      prod;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    mult_rr_scheduler #(.W(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mcand_in  (mcand_in),
        .mplier_in (mplier_in),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .prod      (prod)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_t: 0 = free, otherwise number of cycles since the grant.
    int          m_t      = 0;
    int          m_last   = NREQ - 1;
    int          m_id     = 0;
    int          m_a      = 0;
    int          m_b      = 0;
    int          m_prod   = 0;
    int          m_doneid = 0;
    bit          armed    = 0;
    int          m_sel;
    logic [3:0]  m_gnt;

    always @(negedge clk) begin
        m_sel = -1;
        m_gnt = '0;
        if (m_t == 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (m_sel < 0 && req[(m_last + k) % NREQ]) m_sel = (m_last + k) % NREQ;
            end
            if (m_sel >= 0) m_gnt[m_sel] = 1'b1;
        end
        if (armed) begin
            chk("model_gnt",     32'(gnt),     32'(m_gnt));
            chk("model_busy",    32'(busy),    32'(m_t >= 1));
            chk("model_done",    32'(done),    32'(m_t == W + 1));
            chk("model_prod",    32'(prod),    32'(m_prod));
            chk("model_done_id", 32'(done_id), 32'(m_doneid));
        end
        if (reset) begin
            m_t = 0; m_last = NREQ - 1; m_prod = 0; m_doneid = 0;
            armed = 1;
        end else if (m_t == 0) begin
            if (m_sel >= 0) begin
                m_t    = 1;
                m_id   = m_sel;
                m_last = m_sel;
                m_a    = int'(mcand_in[m_sel*W +: W]);
                m_b    = int'(mplier_in[m_sel*W +: W]);
            end
        end else if (m_t == W + 1) begin
            m_t = 0;
        end else begin
            m_t++;
            if (m_t == W + 1) begin
                m_prod   = m_a * m_b;
                m_doneid = m_id;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int lane, input int a, input int b);
        mcand_in[lane*W +: W]  = W'(a);
        mplier_in[lane*W +: W] = W'(b);
    endtask

    task automatic wait_gnt(input string name, output logic [3:0] g, output int t);
        g = '0;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g = gnt;
                t = cyc;
                break;
            end
        end
        if (t < 0) chk({name, "_gnt_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic wait_done(input string name, output int t);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) chk({name, "_done_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic single_job(input string name, input int lane, input int a, input int b,
                              input int exp_prod);
        logic [3:0] g;
        int tg, td;
        set_ops(lane, a, b);
        req = 4'(1 << lane);
        wait_gnt(name, g, tg);
        chk({name, "_gnt"}, 32'(g), 32'(1 << lane));
        tick();
        req = '0;
        wait_done(name, td);
        chk({name, "_latency"}, 32'(td - tg), 32'(W + 1));
        chk({name, "_prod"},    32'(prod),    32'(exp_prod));
        chk({name, "_id"},      32'(done_id), 32'(lane));
    endtask

    initial begin
        logic [3:0] g;
        int tg, td, tprev;
        bit spurious;

        reset = 1'b1; req = '0; mcand_in = '0; mplier_in = '0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_gnt",  32'(gnt),  32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_prod", 32'(prod), 32'(0));
        chk("rst_id",   32'(done_id), 32'(0));
        tick();

        // Single job: busy is checked one cycle after the grant.
        set_ops(0, 13, 11);
        req = 4'b0001;
        wait_gnt("job0", g, tg);
        chk("job0_gnt", 32'(g), 32'(1));
        tick();
        req = '0;
        #3;
        chk("job0_busy_t1", 32'(busy), 32'(1));
        wait_done("job0", td);
        chk("job0_latency", 32'(td - tg), 32'(5));
        chk("job0_prod", 32'(prod), 32'(143));
        chk("job0_id",   32'(done_id), 32'(0));
        chk("model_pin_143", 32'(m_prod), 32'(143));
        tick();

        single_job("zero", 2, 0, 15, 0);
        tick();
        single_job("max",  2, 15, 15, 225);
        tick();
        single_job("one",  2, 1, 1, 1);
        tick();

        // Wrap: last served lane 2, so lane 0 wins over lane 2.
        set_ops(0, 2, 3);
        set_ops(2, 4, 5);
        req = 4'b0101;
        wait_gnt("wrap_a", g, tg);
        chk("wrap_first", 32'(g), 32'(4'b0001));
        wait_done("wrap_a", td);
        chk("wrap_a_prod", 32'(prod), 32'(6));
        wait_gnt("wrap_b", g, tg);
        chk("wrap_second", 32'(g), 32'(4'b0100));
        tick();
        req = '0;
        wait_done("wrap_b", td);
        chk("wrap_b_prod", 32'(prod), 32'(20));
        chk("wrap_b_id",   32'(done_id), 32'(2));
        tick();

        // Reset restores lane 0 as top priority before contention.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_ops(i, i + 1, 3);
        req = 4'b1111;
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("cont", g, tg);
            chk("cont_order", 32'(g), 32'(1 << (k % NREQ)));
            if (k > 0) chk("cont_spacing", 32'(tg - tprev), 32'(W + 2));
            tprev = tg;
            if (k == 4) begin
                tick();
                req = '0;
            end
            wait_done("cont", td);
            chk("cont_prod", 32'(prod), 32'(((k % NREQ) + 1) * 3));
        end
        tick();

        // Withdrawal: lane 1 requests only while lane 0 is running.
        set_ops(0, 5, 5);
        set_ops(1, 6, 6);
        req = 4'b0001;
        wait_gnt("wd", g, tg);
        chk("wd_gnt", 32'(g), 32'(1));
        tick();
        req = '0;
        tick();
        req = 4'b0010;
        tick(); tick();
        req = '0;
        wait_done("wd", td);
        chk("wd_prod", 32'(prod), 32'(25));
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != '0 || done !== 1'b0) spurious = 1;
        end
        chk("wd_no_spurious", 32'(spurious), 32'(0));
        tick();

        // Reset during RUN aborts the job.
        set_ops(3, 7, 9);
        req = 4'b1000;
        wait_gnt("abort", g, tg);
        chk("abort_gnt", 32'(g), 32'(4'b1000));
        tick();
        req = '0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_prod", 32'(prod), 32'(0));
        chk("abort_id",   32'(done_id), 32'(0));
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done !== 1'b0) spurious = 1;
        end
        chk("abort_no_done", 32'(spurious), 32'(0));
        tick();
        single_job("after_abort", 3, 7, 9, 63);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
